// File: rtl/apb_sw_led_irq_ctrl.sv
// apb_sw_led_irq_ctrl: APB3 slave for debounced switches with sticky edge IRQs and LED outputs.
// Optional PWM brightness register at 0x18 when `APB_SW_LED_PWM_EN is defined.
module apb_sw_led_irq_ctrl #(
    parameter int NUM_SW    = 4,
    parameter int NUM_LED   = 8,
    parameter int DB_CYCLES = 50000,
    parameter int DB_CNT_W  = 16
) (
    input  logic               PCLK,
    input  logic               PRESERN,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [8:0]         PADDR,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    input  logic [NUM_SW-1:0]  SW,
    output logic [NUM_LED-1:0] LED,
    output logic               FABINT
);
    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

    logic [2:0]          idx;
    logic                wr, mapped;
    logic [NUM_SW-1:0]   sync1_q, sync2_q, db_q, chg, ev, w1c, stat_d;
    logic [NUM_SW-1:0]   en_q, stat_q, esel_q;
    logic [DB_CNT_W-1:0] cnt_q [NUM_SW];
    logic [DB_CNT_W-1:0] cnt_d [NUM_SW];
    logic [NUM_LED-1:0]  led_q;
    logic                fabint_q;
    logic [31:0]         rd;
    logic                unused_ok;

    assign idx       = PADDR[4:2];
    assign wr        = PSEL & PENABLE & PWRITE;
    assign PREADY    = 1'b1;
    assign PSLVERR   = PSEL & PENABLE & ~mapped;
    assign FABINT    = fabint_q;
    assign unused_ok = ^{PADDR[8:5], PADDR[1:0], PWDATA};

    // A switch flips only after DB_CYCLES consecutive disagreeing samples
    always_comb begin
        for (int k = 0; k < NUM_SW; k++) begin
            chg[k]   = (sync2_q[k] != db_q[k]) && (cnt_q[k] == DB_LAST);
            cnt_d[k] = (sync2_q[k] == db_q[k] || chg[k]) ? '0 : cnt_q[k] + DB_CNT_W'(1);
        end
    end

    assign ev     = chg & (sync2_q ^ esel_q);
    assign w1c    = (wr && idx == 3'd3) ? PWDATA[NUM_SW-1:0] : '0;
    assign stat_d = (stat_q & ~w1c) | ev;

`ifdef APB_SW_LED_PWM_EN
    logic [7:0] bright_q, pwm_q;

    assign mapped = idx != 3'd7;
    assign LED    = led_q & {NUM_LED{pwm_q < bright_q}};

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            bright_q <= 8'hFF;
            pwm_q    <= '0;
        end else begin
            pwm_q <= pwm_q + 8'd1;
            if (wr && idx == 3'd6) bright_q <= PWDATA[7:0];
        end
    end
`else
    assign mapped = idx < 3'd6;
    assign LED    = led_q;
`endif

    always_comb begin
        case (idx)
            3'd0:    rd = 32'(led_q);
            3'd1:    rd = 32'(db_q);
            3'd2:    rd = 32'(en_q);
            3'd3:    rd = 32'(stat_q);
            3'd4:    rd = 32'(esel_q);
            3'd5:    rd = {16'd0, 8'(NUM_LED), 8'(NUM_SW)};
`ifdef APB_SW_LED_PWM_EN
            3'd6:    rd = {24'd0, bright_q};
`endif
            default: rd = '0;
        endcase
        PRDATA = (PSEL && !PWRITE) ? rd : '0;
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            led_q    <= '0;
            en_q     <= '0;
            stat_q   <= '0;
            esel_q   <= '0;
            fabint_q <= 1'b0;
            for (int k = 0; k < NUM_SW; k++) cnt_q[k] <= '0;
        end else begin
            sync1_q  <= SW;
            sync2_q  <= sync1_q;
            db_q     <= db_q ^ chg;
            stat_q   <= stat_d;
            fabint_q <= |(stat_q & en_q);
            for (int k = 0; k < NUM_SW; k++) cnt_q[k] <= cnt_d[k];
            if (wr && idx == 3'd0) led_q  <= PWDATA[NUM_LED-1:0];
            if (wr && idx == 3'd2) en_q   <= PWDATA[NUM_SW-1:0];
            if (wr && idx == 3'd4) esel_q <= PWDATA[NUM_SW-1:0];
        end
    end
endmodule

// File: tb/tb_apb_sw_led_irq_ctrl.sv
// tb_apb_sw_led_irq_ctrl: directed bench with a window-based behavioural model checked every cycle.
module tb_apb_sw_led_irq_ctrl;
    localparam int DB = 4;

    logic        PCLK = 1'b0, PRESERN, PSEL, PENABLE, PWRITE;
    logic [8:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR, FABINT;
    logic [3:0]  SW;
    logic [7:0]  LED;

    int errors = 0;
    int checks = 0;

    apb_sw_led_irq_ctrl #(.NUM_SW(4), .NUM_LED(8), .DB_CYCLES(DB), .DB_CNT_W(16)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .SW(SW), .LED(LED), .FABINT(FABINT)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Model: a switch's debounced level flips once the last DB synchronised samples all disagree with it
    logic [7:0] led_m, bright_m, pwm_m;
    logic [3:0] en_m, stat_m, esel_m, db_m, ev_m, w1c_m, hv;
    logic       fab_m, wr_m, stable_m;
    logic [3:0] hist[$];

    always @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            led_m = 0; en_m = 0; stat_m = 0; esel_m = 0; db_m = 0; fab_m = 0;
            bright_m = 8'hFF; pwm_m = 0;
            hist = {};
            for (int k = 0; k < DB + 2; k++) hist.push_front(4'h0);
        end else begin
            wr_m  = PSEL && PENABLE && PWRITE;
            fab_m = |(stat_m & en_m);
            hist.push_front(SW);
            void'(hist.pop_back());
            ev_m = 0;
            for (int i = 0; i < 4; i++) begin
                stable_m = 1;
                for (int k = 2; k < DB + 2; k++) begin
                    hv = hist[k];
                    if (hv[i] == db_m[i]) stable_m = 0;
                end
                if (stable_m) begin
                    db_m[i] = ~db_m[i];
                    if (db_m[i] != esel_m[i]) ev_m[i] = 1;
                end
            end
            w1c_m  = (wr_m && PADDR[4:2] == 3) ? PWDATA[3:0] : 4'h0;
            stat_m = (stat_m & ~w1c_m) | ev_m;
            if (wr_m && PADDR[4:2] == 0) led_m = PWDATA[7:0];
            if (wr_m && PADDR[4:2] == 2) en_m = PWDATA[3:0];
            if (wr_m && PADDR[4:2] == 4) esel_m = PWDATA[3:0];
`ifdef APB_SW_LED_PWM_EN
            if (wr_m && PADDR[4:2] == 6) bright_m = PWDATA[7:0];
`endif
            pwm_m = pwm_m + 8'd1;
        end
    end

    function automatic logic [31:0] exp_rd();
        if (!(PSEL && !PWRITE)) return 0;
        case (PADDR[4:2])
            0: return {24'd0, led_m};
            1: return {28'd0, db_m};
            2: return {28'd0, en_m};
            3: return {28'd0, stat_m};
            4: return {28'd0, esel_m};
            5: return 32'h0000_0804;
`ifdef APB_SW_LED_PWM_EN
            6: return {24'd0, bright_m};
`endif
            default: return 0;
        endcase
    endfunction

    function automatic logic exp_err();
`ifdef APB_SW_LED_PWM_EN
        return PSEL && PENABLE && PADDR[4:2] == 7;
`else
        return PSEL && PENABLE && PADDR[4:2] >= 6;
`endif
    endfunction

    function automatic logic [7:0] exp_led();
`ifdef APB_SW_LED_PWM_EN
        return (pwm_m < bright_m) ? led_m : 8'h00;
`else
        return led_m;
`endif
    endfunction

    always @(negedge PCLK) begin
        chk("LED", {24'd0, LED}, {24'd0, exp_led()});
        chk("FABINT", {31'd0, FABINT}, {31'd0, fab_m});
        chk("PRDATA", PRDATA, exp_rd());
        chk("PSLVERR", {31'd0, PSLVERR}, {31'd0, exp_err()});
        chk("PREADY", {31'd0, PREADY}, 32'd1);
    end

    task automatic tick();
        @(posedge PCLK);
        #2;
    endtask

    task automatic apb_write(input logic [8:0] a, input logic [31:0] d);
        tick();
        PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
        tick();
        PENABLE = 1;
        tick();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [8:0] a, output logic [31:0] d, output logic e);
        tick();
        PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
        tick();
        PENABLE = 1;
        @(negedge PCLK);
        d = PRDATA;
        e = PSLVERR;
        tick();
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic peek(input logic [8:0] a);
        PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
        #1;
    endtask

    logic [31:0] d;
    logic        e;
    int          cnt;

    initial begin
        PRESERN = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; SW = 0;
        repeat (2) @(posedge PCLK);
        #2 PRESERN = 1;
        chk("reset_led", {24'd0, LED}, 0);
        chk("reset_fabint", {31'd0, FABINT}, 0);

        apb_write(9'h00, 32'hA5);
        chk("t1_led", {24'd0, LED}, 32'hA5);
        apb_read(9'h00, d, e);
        chk("t1_rd_led", d, 32'h0000_00A5);
        chk("t1_no_err", {31'd0, e}, 0);
        apb_read(9'h14, d, e);
        chk("t1_cfg", d, 32'h0000_0804);

        peek(9'h04);
        SW = 4'h1;
        repeat (3) tick();
        SW = 4'h0;
        repeat (8) tick();
        chk("t2_glitch_sw", PRDATA, 0);
        peek(9'h0C);
        chk("t2_glitch_stat", PRDATA, 0);
        peek(9'h04);
        SW = 4'h1;
        repeat (5) tick();
        chk("t2_sw_cycle5", PRDATA, 0);
        tick();
        chk("t2_sw_cycle6", PRDATA, 1);
        peek(9'h0C);
        chk("t2_rise_stat", PRDATA, 1);
        PSEL = 0;

        apb_write(9'h0C, 32'hF);
        SW = 4'h0;
        repeat (8) tick();
        apb_read(9'h0C, d, e);
        chk("t3_fall_no_event", d, 0);
        apb_write(9'h08, 32'h1);
        peek(9'h0C);
        SW = 4'h1;
        repeat (6) tick();
        chk("t3_stat_set", PRDATA, 1);
        chk("t3_fab_not_yet", {31'd0, FABINT}, 0);
        tick();
        chk("t3_fab_set", {31'd0, FABINT}, 1);
        PSEL = 0;
        apb_write(9'h0C, 32'h1);
        chk("t3_fab_hold", {31'd0, FABINT}, 1);
        tick();
        chk("t3_fab_clear", {31'd0, FABINT}, 0);
        apb_read(9'h0C, d, e);
        chk("t3_stat_clear", d, 0);

        apb_write(9'h10, 32'h2);
        SW = 4'h3;
        repeat (8) tick();
        apb_read(9'h0C, d, e);
        chk("t4_rise_ignored", d, 0);
        SW = 4'h1;
        repeat (8) tick();
        apb_read(9'h0C, d, e);
        chk("t4_fall_sets", d, 2);
        SW = 4'h3;
        repeat (8) tick();
        apb_write(9'h0C, 32'h2);
        apb_read(9'h0C, d, e);
        chk("t4_cleared", d, 0);
        SW = 4'h1;
        repeat (3) tick();
        apb_write(9'h0C, 32'h2);
        apb_read(9'h0C, d, e);
        chk("t4_set_wins", d, 2);

        apb_write(9'h08, 32'h3);
        tick();
        chk("t5_fab_before", {31'd0, FABINT}, 1);
        apb_read(9'h1C, d, e);
        chk("t5_unmapped_err", {31'd0, e}, 1);
        chk("t5_unmapped_rd", d, 0);
        apb_write(9'h1C, 32'hFFFF_FFFF);
        apb_write(9'h04, 32'hF);
        apb_write(9'h14, 32'hFFFF_FFFF);
        apb_read(9'h00, d, e);
        chk("t5_led_kept", d, 32'hA5);
        apb_read(9'h04, d, e);
        chk("t5_sw_kept", d, 1);
        apb_read(9'h14, d, e);
        chk("t5_cfg_kept", d, 32'h0000_0804);
        SW = 4'h0;
        repeat (2) tick();
        PRESERN = 0;
        #1;
        chk("t5_rst_led", {24'd0, LED}, 0);
        chk("t5_rst_fab", {31'd0, FABINT}, 0);
        chk("t5_rst_prdata", PRDATA, 0);
        chk("t5_rst_err", {31'd0, PSLVERR}, 0);
        SW = 4'h1;
        tick();
        PRESERN = 1;
        peek(9'h04);
        repeat (5) tick();
        chk("t5_rel_cycle5", PRDATA, 0);
        tick();
        chk("t5_rel_cycle6", PRDATA, 1);
        peek(9'h0C);
        chk("t5_rel_rise", PRDATA, 1);
        PSEL = 0;

`ifdef APB_SW_LED_PWM_EN
        apb_read(9'h18, d, e);
        chk("t6_bright_reset", d, 32'hFF);
        apb_write(9'h18, 32'd64);
        apb_write(9'h00, 32'h1);
        cnt = 0;
        repeat (256) begin
            tick();
            cnt += int'(LED[0]);
        end
        chk("t6_duty64", 32'(cnt), 64);
        apb_write(9'h18, 32'd0);
        cnt = 0;
        repeat (256) begin
            tick();
            cnt += int'(LED[0]);
        end
        chk("t6_duty0", 32'(cnt), 0);
`else
        apb_read(9'h18, d, e);
        chk("t6_no_bright_err", {31'd0, e}, 1);
        chk("t6_no_bright_rd", d, 0);
        cnt = 0;
`endif
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
